alu_control_sequencer: RTL and testbench
========================================

// Module: alu_control_sequencer
// PURPOSE
//  Drives the ALU: fetches 9-bit instructions and decodes them into Type/RTypeOP/ITypeOP/operand/immediate.
//  Sources AccumulatorIn from the accumulator register it owns, then consumes ALU Out/Branch to update that
//  accumulator, the register file and the PC. Sits between instruction ROM, register file and ALU; one
//  instruction completes every 4 cycles (FETCH/DECODE/EXECUTE/WRITEBACK).
// PARAMETERS
//  PC_W      10  program counter / instruction address width
//  REG_IDX_W 4   register file index width
// PORTS
//  Clk           in   1        clock, all state updates on rising edge
//  Reset         in   1        synchronous, active-high reset
//  Start         in   1        begin execution at PC 0 (sampled in IDLE/HALT only)
//  InstrAddr     out  PC_W     instruction ROM address (= PC)
//  InstrData     in   9        ROM data, valid 1 cycle after InstrAddr (synchronous ROM)
//  RegReadIdx    out  4        register file read index (combinational read)
//  RegReadData   in   8        register file read data
//  RegWriteEn    out  1        register write strobe, 1-cycle pulse
//  RegWriteIdx   out  4        register write index
//  RegWriteData  out  8        register write data (= accumulator)
//  LutIdx        out  5        branch-target LUT index (= instruction imm field)
//  LutTarget     in   PC_W     branch-target LUT data (combinational)
//  AccumulatorIn out  8        to ALU AccumulatorIn (accumulator register)
//  OperandIn     out  8        to ALU OperandIn (latched RegReadData)
//  ImmediateIn   out  8        to ALU ImmediateIn ({3'b0, imm5})
//  Type          out  1        to ALU Type (1 = R-type, 0 = I-type)
//  RTypeOP       out  4        to ALU RTypeOP
//  ITypeOP       out  3        to ALU ITypeOP
//  AluOut        in   8        from ALU Out
//  AluBranch     in   1        from ALU Branch
//  Done          out  1        high while in HALT
// BEHAVIOUR
//  Encoding: [8]=Type. R: [7:4]=RTypeOP, [3:0]=reg idx. I: [7:5]=ITypeOP, [4:0]=imm5.
//  Special ops: R 4'hF HALT; R 4'hE STORE (reg<=acc); R 4'hD LOAD (acc<=RegReadData); I 3'b111 BRANCH.
//   All other ops: acc <= AluOut in WRITEBACK.
//  Reset: state IDLE, PC=0, acc=0, instr reg=0, OperandIn=0; all outputs 0; Done=0.
//  FSM: IDLE -Start-> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; WRITEBACK of HALT -> HALT.
//   HALT -Start-> FETCH with PC=0, acc=0; Start ignored in FETCH..WRITEBACK.
//  FETCH: InstrAddr=PC. DECODE: latch InstrData into instr reg; drive RegReadIdx=idx.
//  EXECUTE: OperandIn latched from RegReadData at DECODE->EXECUTE edge; ALU controls valid for the whole
//   of EXECUTE; AluOut/AluBranch captured at EXECUTE->WRITEBACK edge.
//  WRITEBACK: acc update per op; STORE asserts RegWriteEn for exactly this cycle;
//   PC <= (BRANCH && captured Branch) ? LutTarget : PC+1, with wrap 2^PC_W-1 -> 0.
//   HALT does not advance PC.
//  Control outputs (Type/RTypeOP/ITypeOP/ImmediateIn) are driven from the instr reg and held stable
//   DECODE..WRITEBACK; no glitching mid-instruction.
//  Reset in any state, including WRITEBACK: the same cycle's RegWriteEn is suppressed; next cycle is IDLE
//   with reset values.
//  Start and Reset both high: Reset wins.
//  Arithmetic: 8-bit, no saturation; the ALU owns all carries and flags.
// STRUCTURE
//  Package isa_pkg: typedef enum state_t {IDLE,FETCH,DECODE,EXECUTE,WRITEBACK,HALT}; opcode constants
//   OP_HALT, OP_STORE, OP_LOAD, OP_BRANCH; instr field typedef (struct packed, 9 bits).
//  Sub-module instr_decode: combinational field split and special-op flags (is_halt/is_store/is_load/is_branch).
//  Top: FSM, PC, accumulator, operand/result capture registers.
// TESTING (bench uses ROM/regfile/LUT models and a stub ALU driving AluOut/AluBranch)
//  1 Reset, Start, ROM[0]=I op 3'b000 imm 5, stub AluOut=8'h2A -> ImmediateIn=8'h05 in EXECUTE;
//    AccumulatorIn=8'h2A and InstrAddr=1 four cycles after FETCH.
//  2 acc=8'h2A, ROM=R STORE idx 3 -> RegWriteEn=1 for exactly one cycle with idx 3, data 8'h2A.
//  3 ROM=I BRANCH imm 7, LutTarget=10'h040: AluBranch=1 -> next PC 10'h040; AluBranch=0 -> PC+1.
//  4 ROM=R HALT at PC 4 -> Done=1, InstrAddr held at 4 for 20 cycles; Start -> FETCH at PC 0, acc=0, Done=0.
//  5 PC=10'h3FF, non-branch op -> next InstrAddr=10'h000.
//  6 Reset asserted during WRITEBACK of STORE -> RegWriteEn stays 0; next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg: state encoding, special opcodes and instruction layout shared by the ALU control sequencer
package isa_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam logic [3:0] OP_STORE  = 4'hE;
  localparam logic [3:0] OP_LOAD   = 4'hD;
  localparam logic [2:0] OP_BRANCH = 3'b111;
  typedef struct packed {
    logic       typ;
    logic [7:0] body;
  } instr_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: splits a 9-bit instruction into ALU control fields and special-op flags
module instr_decode
  import isa_pkg::*;
(
  input  logic [8:0] instr,
  output logic       typ,
  output logic [3:0] rtype_op,
  output logic [2:0] itype_op,
  output logic [3:0] idx,
  output logic [4:0] imm,
  output logic       is_halt,
  output logic       is_store,
  output logic       is_load,
  output logic       is_branch
);
  instr_t i;
  assign i         = instr;
  assign typ       = i.typ;
  assign rtype_op  = i.body[7:4];
  assign idx       = i.body[3:0];
  assign itype_op  = i.body[7:5];
  assign imm       = i.body[4:0];
  assign is_halt   = typ && rtype_op == OP_HALT;
  assign is_store  = typ && rtype_op == OP_STORE;
  assign is_load   = typ && rtype_op == OP_LOAD;
  assign is_branch = !typ && itype_op == OP_BRANCH;
endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: 4-cycle fetch/decode/execute/writeback sequencer driving an external ALU
module alu_control_sequencer
  import isa_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int REG_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [PC_W-1:0]      instr_addr,
  input  logic [8:0]           instr_data,
  output logic [REG_IDX_W-1:0] reg_read_idx,
  input  logic [7:0]           reg_read_data,
  output logic                 reg_write_en,
  output logic [REG_IDX_W-1:0] reg_write_idx,
  output logic [7:0]           reg_write_data,
  output logic [4:0]           lut_idx,
  input  logic [PC_W-1:0]      lut_target,
  output logic [7:0]           accumulator_in,
  output logic [7:0]           operand_in,
  output logic [7:0]           immediate_in,
  output logic                 instr_type,
  output logic [3:0]           rtype_op,
  output logic [2:0]           itype_op,
  input  logic [7:0]           alu_out,
  input  logic                 alu_branch,
  output logic                 done
);
  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      acc, operand, alu_res;
  logic [8:0]      ir, cur;
  logic            br;
  logic [3:0]      idx;
  logic [4:0]      imm;
  logic            is_halt, is_store, is_load, is_branch;
  assign cur = state == DECODE ? instr_data : ir;
  instr_decode u_dec (
    .instr(cur), .typ(instr_type), .rtype_op(rtype_op), .itype_op(itype_op), .idx(idx), .imm(imm),
    .is_halt(is_halt), .is_store(is_store), .is_load(is_load), .is_branch(is_branch)
  );
  assign instr_addr     = pc;
  assign reg_read_idx   = REG_IDX_W'(idx);
  assign reg_write_idx  = REG_IDX_W'(idx);
  assign reg_write_data = acc;
  assign reg_write_en   = !reset && state == WRITEBACK && is_store;
  assign lut_idx        = imm;
  assign accumulator_in = acc;
  assign operand_in     = operand;
  assign immediate_in   = {3'b000, imm};
  assign done           = state == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      acc     <= '0;
      ir      <= '0;
      operand <= '0;
      alu_res <= '0;
      br      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          state <= FETCH;
          pc    <= '0;
          acc   <= '0;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          state   <= EXECUTE;
          ir      <= instr_data;
          operand <= reg_read_data;
        end
        EXECUTE: begin
          state   <= WRITEBACK;
          alu_res <= alu_out;
          br      <= alu_branch;
        end
        WRITEBACK: begin
          state <= is_halt ? HALT : FETCH;
          pc    <= is_halt ? pc : (is_branch && br) ? lut_target : pc + PC_W'(1);
          acc   <= (is_halt || is_store || is_branch) ? acc : is_load ? operand : alu_res;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: directed checks of the sequencer against ROM, regfile, LUT and stub-ALU models
module tb_alu_control_sequencer;
  logic       clk, reset, start;
  logic [9:0] instr_addr, lut_target;
  logic [8:0] instr_data;
  logic [3:0] reg_read_idx, reg_write_idx, rtype_op;
  logic [7:0] reg_read_data, reg_write_data, accumulator_in, operand_in, immediate_in, alu_out;
  logic       reg_write_en, instr_type, alu_branch, done;
  logic [4:0] lut_idx;
  logic [2:0] itype_op;
  logic [8:0] rom [1024];
  logic [7:0] rf [16];
  logic [9:0] lut [32];
  int         wr_cnt, vectors, miscompares, wc;
  logic [7:0] last_wr_data;
  alu_control_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr), .instr_data(instr_data),
    .reg_read_idx(reg_read_idx), .reg_read_data(reg_read_data), .reg_write_en(reg_write_en),
    .reg_write_idx(reg_write_idx), .reg_write_data(reg_write_data), .lut_idx(lut_idx),
    .lut_target(lut_target), .accumulator_in(accumulator_in), .operand_in(operand_in),
    .immediate_in(immediate_in), .instr_type(instr_type), .rtype_op(rtype_op), .itype_op(itype_op),
    .alu_out(alu_out), .alu_branch(alu_branch), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) instr_data <= rom[instr_addr];
  assign reg_read_data = rf[reg_read_idx];
  assign lut_target    = lut[lut_idx];
  always @(posedge clk) if (reg_write_en) begin
    wr_cnt       <= wr_cnt + 1;
    last_wr_data <= reg_write_data;
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    step(2);
    reset = 1'b0;
    start = 1'b0;
    step(1);
    vectors++; if ({instr_addr, accumulator_in, operand_in, immediate_in} !== 34'h0) begin miscompares++; $display("FAIL reset_data got %h/%h/%h/%h want 0", instr_addr, accumulator_in, operand_in, immediate_in); end
    vectors++; if ({instr_type, rtype_op, itype_op, lut_idx, reg_write_en, reg_write_data, done} !== 23'h0) begin miscompares++; $display("FAIL reset_ctrl got %b%h%h%h%b%h%b want 0", instr_type, rtype_op, itype_op, lut_idx, reg_write_en, reg_write_data, done); end
    step(3);
    vectors++; if (instr_addr !== 10'h000 || done !== 1'b0) begin miscompares++; $display("FAIL idle_hold got addr %h done %b want 000/0", instr_addr, done); end
  endtask
  task automatic test_itype();
    rom[0] = 9'h005;
    rom[1] = 9'h1E3;
    rom[2] = 9'h0E7;
    rom[10'h040] = 9'h0E7;
    lut[7] = 10'h040;
    alu_out = 8'h2A;
    alu_branch = 1'b0;
    do_reset();
    go();
    vectors++; if (instr_addr !== 10'h000) begin miscompares++; $display("FAIL t1_fetch_addr got %h want 000", instr_addr); end
    step(2);
    vectors++; if (immediate_in !== 8'h05) begin miscompares++; $display("FAIL t1_imm got %h want 05", immediate_in); end
    vectors++; if (instr_type !== 1'b0 || itype_op !== 3'b000) begin miscompares++; $display("FAIL t1_ctrl got %b/%b want 0/000", instr_type, itype_op); end
    step(2);
    vectors++; if (accumulator_in !== 8'h2A) begin miscompares++; $display("FAIL t1_acc got %h want 2a", accumulator_in); end
    vectors++; if (instr_addr !== 10'h001) begin miscompares++; $display("FAIL t1_next_addr got %h want 001", instr_addr); end
  endtask
  task automatic test_store();
    step(2);
    vectors++; if (reg_write_en !== 1'b0) begin miscompares++; $display("FAIL t2_early_we got %b want 0", reg_write_en); end
    vectors++; if (instr_type !== 1'b1 || rtype_op !== 4'hE) begin miscompares++; $display("FAIL t2_ctrl got %b/%h want 1/e", instr_type, rtype_op); end
    wc = wr_cnt;
    step(1);
    vectors++; if (reg_write_en !== 1'b1 || reg_write_idx !== 4'd3 || reg_write_data !== 8'h2A) begin miscompares++; $display("FAIL t2_write got en %b idx %h data %h want 1/3/2a", reg_write_en, reg_write_idx, reg_write_data); end
    step(1);
    vectors++; if (reg_write_en !== 1'b0) begin miscompares++; $display("FAIL t2_we_pulse got %b want 0", reg_write_en); end
    vectors++; if (wr_cnt !== wc + 1 || last_wr_data !== 8'h2A) begin miscompares++; $display("FAIL t2_writes got %0d/%h want %0d/2a", wr_cnt - wc, last_wr_data, 1); end
    vectors++; if (instr_addr !== 10'h002 || accumulator_in !== 8'h2A) begin miscompares++; $display("FAIL t2_after got %h/%h want 002/2a", instr_addr, accumulator_in); end
  endtask
  task automatic test_branch();
    alu_branch = 1'b1;
    step(2);
    vectors++; if (lut_idx !== 5'd7 || immediate_in !== 8'h07) begin miscompares++; $display("FAIL t3_lut_idx got %h/%h want 07/07", lut_idx, immediate_in); end
    step(2);
    vectors++; if (instr_addr !== 10'h040) begin miscompares++; $display("FAIL t3_taken got %h want 040", instr_addr); end
    vectors++; if (accumulator_in !== 8'h2A) begin miscompares++; $display("FAIL t3_acc got %h want 2a", accumulator_in); end
    alu_branch = 1'b0;
    step(1);
    start = 1'b1;
    step(2);
    start = 1'b0;
    step(1);
    vectors++; if (instr_addr !== 10'h041) begin miscompares++; $display("FAIL t3_not_taken got %h want 041", instr_addr); end
  endtask
  task automatic test_load();
    rf[2] = 8'h5C;
    rom[0] = 9'h1D2;
    rom[1] = 9'h132;
    alu_out = 8'hFF;
    do_reset();
    go();
    step(1);
    vectors++; if (reg_read_idx !== 4'd2) begin miscompares++; $display("FAIL load_ridx got %h want 2", reg_read_idx); end
    step(1);
    vectors++; if (operand_in !== 8'h5C) begin miscompares++; $display("FAIL load_operand got %h want 5c", operand_in); end
    step(2);
    vectors++; if (accumulator_in !== 8'h5C) begin miscompares++; $display("FAIL load_acc got %h want 5c", accumulator_in); end
    alu_out = 8'h77;
    step(2);
    vectors++; if (rtype_op !== 4'h3 || instr_type !== 1'b1) begin miscompares++; $display("FAIL rop_ctrl got %h/%b want 3/1", rtype_op, instr_type); end
    step(2);
    vectors++; if (accumulator_in !== 8'h77 || instr_addr !== 10'h002) begin miscompares++; $display("FAIL rop_acc got %h/%h want 77/002", accumulator_in, instr_addr); end
  endtask
  task automatic test_halt();
    for (int i = 0; i < 4; i++) rom[i] = 9'h001;
    rom[4] = 9'h1F0;
    alu_out = 8'h11;
    do_reset();
    go();
    step(16);
    vectors++; if (instr_addr !== 10'h004 || done !== 1'b0) begin miscompares++; $display("FAIL t4_pre got %h/%b want 004/0", instr_addr, done); end
    step(4);
    vectors++; if (done !== 1'b1 || instr_addr !== 10'h004 || accumulator_in !== 8'h11) begin miscompares++; $display("FAIL t4_halt got %b/%h/%h want 1/004/11", done, instr_addr, accumulator_in); end
    step(20);
    vectors++; if (done !== 1'b1 || instr_addr !== 10'h004) begin miscompares++; $display("FAIL t4_hold got %b/%h want 1/004", done, instr_addr); end
    go();
    vectors++; if (done !== 1'b0 || instr_addr !== 10'h000 || accumulator_in !== 8'h00) begin miscompares++; $display("FAIL t4_restart got %b/%h/%h want 0/000/00", done, instr_addr, accumulator_in); end
  endtask
  task automatic test_wrap();
    lut[9] = 10'h3FF;
    rom[0] = 9'h0E9;
    rom[10'h3FF] = 9'h003;
    alu_branch = 1'b1;
    alu_out = 8'h33;
    do_reset();
    go();
    step(4);
    vectors++; if (instr_addr !== 10'h3FF) begin miscompares++; $display("FAIL t5_top got %h want 3ff", instr_addr); end
    alu_branch = 1'b0;
    step(4);
    vectors++; if (instr_addr !== 10'h000 || accumulator_in !== 8'h33) begin miscompares++; $display("FAIL t5_wrap got %h/%h want 000/33", instr_addr, accumulator_in); end
  endtask
  task automatic test_reset_writeback();
    rf[5] = 8'hAA;
    rom[0] = 9'h1E5;
    alu_out = 8'h00;
    do_reset();
    go();
    step(3);
    vectors++; if (reg_write_en !== 1'b1) begin miscompares++; $display("FAIL t6_wb_armed got %b want 1", reg_write_en); end
    wc = wr_cnt;
    reset = 1'b1;
    #1;
    vectors++; if (reg_write_en !== 1'b0) begin miscompares++; $display("FAIL t6_we_gated got %b want 0", reg_write_en); end
    step(1);
    vectors++; if (wr_cnt !== wc) begin miscompares++; $display("FAIL t6_no_write got %0d writes want 0", wr_cnt - wc); end
    vectors++; if ({instr_addr, accumulator_in, operand_in, immediate_in, instr_type, rtype_op, itype_op, lut_idx, reg_write_en, done} !== 49'h0) begin miscompares++; $display("FAIL t6_outputs got %h/%h/%h/%h/%b/%h/%h/%h/%b/%b want 0", instr_addr, accumulator_in, operand_in, immediate_in, instr_type, rtype_op, itype_op, lut_idx, reg_write_en, done); end
    reset = 1'b0;
    step(4);
    vectors++; if (instr_addr !== 10'h000 || done !== 1'b0 || reg_write_en !== 1'b0) begin miscompares++; $display("FAIL t6_idle got %h/%b/%b want 000/0/0", instr_addr, done, reg_write_en); end
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    wr_cnt = 0;
    last_wr_data = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    alu_out = 8'h00;
    alu_branch = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h1F0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    for (int i = 0; i < 32; i++) lut[i] = 10'h000;
    test_reset();
    test_itype();
    test_store();
    test_branch();
    test_load();
    test_halt();
    test_wrap();
    test_reset_writeback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
